pwm_duty_sequencer: RTL and testbench
=====================================

PWM_DUTY_SEQUENCER -- requirements
Module: pwm_duty_sequencer

Interface
REQ-001 Parameter PERIOD, default 100: PWM period in clk cycles; duty is expressed in percent, 0..PERIOD.
REQ-002 Parameter STEP, default 10: increment/decrement size applied to the target per button request.
REQ-003 Parameter RESTART_DUTY, default 50: duty loaded by restart and by reset.
REQ-004 Parameter PRESET_HI, default 75, and PRESET_LO, default 25: preset target duties.
REQ-005 clk  input  1  the single clock; all state is updated on its rising edge.
REQ-006 rst_n  input  1  reset; it is asynchronous and active-low.
REQ-007 restart, preset_hi, preset_lo, inc, dec  input  1 each  debounced button levels; each request fires on the rising edge.
REQ-008 pwm_out  output  1  PWM waveform.
REQ-009 duty_value  output  7  currently applied duty, 0..PERIOD, for display and VGA consumers.
REQ-010 target_value  output  7  requested duty.
REQ-011 busy  output  1  high while duty_value differs from target_value.

Function
REQ-012 The block SHALL register each request input and SHALL detect a request when the current sample is 1 and the previous sample is 0; a held level SHALL produce exactly one request.
REQ-013 Requests detected in the same cycle SHALL be arbitrated by fixed priority: restart > preset_hi > preset_lo > inc > dec; lower-priority requests in that cycle SHALL be dropped, not queued.
REQ-014 inc SHALL set target to min(target+STEP, PERIOD); dec SHALL set target to max(target-STEP, 0); arithmetic SHALL use at least 8 bits so that no wrap-around occurs.
REQ-015 preset_hi and preset_lo SHALL set target to PRESET_HI and PRESET_LO respectively; the target SHALL update one cycle after the rising edge is sampled.
REQ-016 The period counter SHALL count 0..PERIOD-1 and wrap to 0; pwm_out SHALL be high when counter < duty_value (registered output); duty 0 gives constant low and duty PERIOD gives constant high.
REQ-017 FSM states: HOLD (duty==target) and RAMP (duty!=target); HOLD->RAMP when a request changes the target; RAMP->HOLD when duty reaches target.
REQ-018 In RAMP, duty_value SHALL move by exactly 1 toward target only on the cycle where counter==PERIOD-1, so that the duty never changes mid-period.
REQ-019 A request accepted during RAMP SHALL retarget immediately; ramp direction SHALL follow the new target with no overshoot.
REQ-020 restart SHALL set both target and duty_value to RESTART_DUTY, SHALL clear the counter to 0 in the next cycle, and SHALL force HOLD regardless of the current state.
REQ-021 busy SHALL equal (state==RAMP), registered.

Reset
REQ-022 While rst_n=0: counter=0, target=duty=RESTART_DUTY, state=HOLD, pwm_out=0, busy=0, all edge-detect history registers =1 (so that buttons held through reset do not fire).
REQ-023 Reset asserted mid-ramp SHALL abandon the ramp; after release, operation SHALL resume from the reset values with no pending request.

Structure
REQ-024 The FSM state encoding, the default PERIOD/STEP/preset constants and the request-priority encoding SHALL live in shared package pwm_ctrl_pkg.
REQ-025 Edge detection SHALL be a sub-module rise_detect (clk, rst_n, in, pulse), instantiated five times.
REQ-026 The implementation SHALL contain no multipliers or dividers; only compare, add and subtract are permitted.

Verification
REQ-027 After reset, pulse inc once -> target_value=60 next cycle; duty_value reaches 60 after 10 period boundaries (1000 clk); busy then falls.
REQ-028 With target=100, pulse inc -> target stays 100; with target=0, pulse dec -> target stays 0; pwm_out is constant high or constant low accordingly.
REQ-029 Raise restart, preset_hi and inc in the same cycle while in RAMP -> duty=target=50, counter=0, busy=0, and no later change from inc or preset_hi.
REQ-030 Pulse preset_hi (duty 50→ramping), then preset_lo at duty=60 -> duty reverses to 25 with no value exceeding 60; duty changes only at counter==99.
REQ-031 Hold inc high for 500 cycles -> target +10 exactly once; assert rst_n=0 mid-ramp -> all outputs return to REQ-022 values asynchronously.
REQ-032 With duty=30, measure pwm_out -> exactly 30 high cycles per 100-cycle period, across 3 consecutive periods.

Source files
------------

// File: rtl/pwm_ctrl_pkg.sv
// Shared constants, state/request encodings and request arbitration for the
// PWM duty sequencer.
package pwm_ctrl_pkg;

  localparam int unsigned DEF_PERIOD       = 100;
  localparam int unsigned DEF_STEP         = 10;
  localparam int unsigned DEF_RESTART_DUTY = 50;
  localparam int unsigned DEF_PRESET_HI    = 75;
  localparam int unsigned DEF_PRESET_LO    = 25;

  // Bit positions of each button inside the packed request vector.
  localparam int unsigned REQ_IDX_RESTART   = 4;
  localparam int unsigned REQ_IDX_PRESET_HI = 3;
  localparam int unsigned REQ_IDX_PRESET_LO = 2;
  localparam int unsigned REQ_IDX_INC       = 1;
  localparam int unsigned REQ_IDX_DEC       = 0;

  typedef enum logic {
    ST_HOLD = 1'b0,
    ST_RAMP = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    REQ_NONE      = 3'd0,
    REQ_RESTART   = 3'd1,
    REQ_PRESET_HI = 3'd2,
    REQ_PRESET_LO = 3'd3,
    REQ_INC       = 3'd4,
    REQ_DEC       = 3'd5
  } req_e;

  // Fixed priority: restart > preset_hi > preset_lo > inc > dec.
  function automatic req_e arbitrate(input logic [4:0] req);
    req_e winner;
    if (req[REQ_IDX_RESTART]) begin
      winner = REQ_RESTART;
    end else if (req[REQ_IDX_PRESET_HI]) begin
      winner = REQ_PRESET_HI;
    end else if (req[REQ_IDX_PRESET_LO]) begin
      winner = REQ_PRESET_LO;
    end else if (req[REQ_IDX_INC]) begin
      winner = REQ_INC;
    end else if (req[REQ_IDX_DEC]) begin
      winner = REQ_DEC;
    end else begin
      winner = REQ_NONE;
    end
    return winner;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Registers a debounced button level and flags its 0->1 transition.
// History resets to 1 so a button held through reset never fires.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic pulse
);

  logic sample_r;
  logic prev_r;

  // Two-stage sample history of the button level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_r <= 1'b1;
      prev_r   <= 1'b1;
    end else begin
      sample_r <= in;
      prev_r   <= sample_r;
    end
  end

  assign pulse = sample_r & ~prev_r;

endmodule

// File: rtl/pwm_duty_sequencer.sv
// Button-driven PWM duty sequencer: requests move a target duty and the
// applied duty ramps toward it one step per PWM period.
module pwm_duty_sequencer
  import pwm_ctrl_pkg::*;
#(
  parameter int unsigned PERIOD       = DEF_PERIOD,
  parameter int unsigned STEP         = DEF_STEP,
  parameter int unsigned RESTART_DUTY = DEF_RESTART_DUTY,
  parameter int unsigned PRESET_HI    = DEF_PRESET_HI,
  parameter int unsigned PRESET_LO    = DEF_PRESET_LO
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       restart,
  input  logic       preset_hi,
  input  logic       preset_lo,
  input  logic       inc,
  input  logic       dec,
  output logic       pwm_out,
  output logic [6:0] duty_value,
  output logic [6:0] target_value,
  output logic       busy
);

  localparam logic [6:0] PERIOD_D  = 7'(PERIOD);
  localparam logic [6:0] LAST_CNT  = 7'(PERIOD - 1);
  localparam logic [6:0] RESTART_D = 7'(RESTART_DUTY);
  localparam logic [6:0] HI_D      = 7'(PRESET_HI);
  localparam logic [6:0] LO_D      = 7'(PRESET_LO);
  localparam logic [7:0] PERIOD_B  = 8'(PERIOD);
  localparam logic [7:0] STEP_B    = 8'(STEP);

  logic [4:0] btn_s;
  logic [4:0] pulse_s;
  req_e       req_s;

  state_e     state_r;
  logic [6:0] counter_r;
  logic [6:0] duty_r;
  logic [6:0] target_r;
  logic       pwm_r;
  logic       busy_r;

  logic [7:0] inc_sum_s;
  logic [7:0] dec_diff_s;
  logic       wrap_s;
  logic [6:0] target_nxt_s;
  logic [6:0] duty_nxt_s;
  logic [6:0] counter_nxt_s;
  state_e     state_nxt_s;

  assign btn_s = {restart, preset_hi, preset_lo, inc, dec};

  for (genvar i = 0; i < 5; i++) begin : g_edge
    rise_detect u_rise (
      .clk   (clk),
      .rst_n (rst_n),
      .in    (btn_s[i]),
      .pulse (pulse_s[i])
    );
  end

  assign req_s      = arbitrate(pulse_s);
  assign inc_sum_s  = {1'b0, target_r} + STEP_B;
  assign dec_diff_s = {1'b0, target_r} - STEP_B;
  assign wrap_s     = (counter_r == LAST_CNT);

  // Next target from the winning request, with clamping at both ends.
  always_comb begin
    target_nxt_s = target_r;
    case (req_s)
      REQ_RESTART:   target_nxt_s = RESTART_D;
      REQ_PRESET_HI: target_nxt_s = HI_D;
      REQ_PRESET_LO: target_nxt_s = LO_D;
      REQ_INC: begin
        if (inc_sum_s > PERIOD_B) begin
          target_nxt_s = PERIOD_D;
        end else begin
          target_nxt_s = inc_sum_s[6:0];
        end
      end
      REQ_DEC: begin
        if ({1'b0, target_r} < STEP_B) begin
          target_nxt_s = 7'd0;
        end else begin
          target_nxt_s = dec_diff_s[6:0];
        end
      end
      default: target_nxt_s = target_r;
    endcase
  end

  // Counter, duty step and state; the duty steps toward the new target so a
  // mid-ramp retarget reverses direction without overshoot.
  always_comb begin
    counter_nxt_s = counter_r + 7'd1;
    duty_nxt_s    = duty_r;
    if (req_s == REQ_RESTART) begin
      counter_nxt_s = 7'd0;
      duty_nxt_s    = RESTART_D;
    end else if (wrap_s) begin
      counter_nxt_s = 7'd0;
      if (duty_r < target_nxt_s) begin
        duty_nxt_s = duty_r + 7'd1;
      end else if (duty_r > target_nxt_s) begin
        duty_nxt_s = duty_r - 7'd1;
      end else begin
        duty_nxt_s = duty_r;
      end
    end else begin
      counter_nxt_s = counter_r + 7'd1;
      duty_nxt_s    = duty_r;
    end
    if (duty_nxt_s != target_nxt_s) begin
      state_nxt_s = ST_RAMP;
    end else begin
      state_nxt_s = ST_HOLD;
    end
  end

  // HOLD/RAMP state machine with registered PWM and busy outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_HOLD;
      counter_r <= 7'd0;
      duty_r    <= RESTART_D;
      target_r  <= RESTART_D;
      pwm_r     <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      counter_r <= counter_nxt_s;
      duty_r    <= duty_nxt_s;
      target_r  <= target_nxt_s;
      pwm_r     <= (counter_nxt_s < duty_nxt_s);
      busy_r    <= (state_nxt_s == ST_RAMP);
    end
  end

  assign pwm_out      = pwm_r;
  assign duty_value   = duty_r;
  assign target_value = target_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Directed bench for pwm_duty_sequencer with hand-computed expectations.
module tb_pwm_duty_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       restart, preset_hi, preset_lo, inc, dec;
  logic       pwm_out;
  logic [6:0] duty_value;
  logic [6:0] target_value;
  logic       busy;

  int total_cnt  = 0;
  int passed_cnt = 0;

  pwm_duty_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .restart      (restart),
    .preset_hi    (preset_hi),
    .preset_lo    (preset_lo),
    .inc          (inc),
    .dec          (dec),
    .pwm_out      (pwm_out),
    .duty_value   (duty_value),
    .target_value (target_value),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total_cnt++;
    if (got == exp) begin
      passed_cnt++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: restart   = v;
      1: preset_hi = v;
      2: preset_lo = v;
      3: inc       = v;
      4: dec       = v;
      default: ;
    endcase
  endtask

  // Target is updated on the second edge after the button rises.
  task automatic press(input int b);
    set_btn(b, 1'b1);
    step(2);
    set_btn(b, 1'b0);
    step(1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget && busy; i++) step(1);
    check(tag, busy, 0);
  endtask

  task automatic count_high(input int n, output int hi);
    hi = 0;
    for (int i = 0; i < n; i++) begin
      if (pwm_out) hi++;
      step(1);
    end
  endtask

  int hi;
  int cyc, last, prev, max_duty;

  initial begin
    rst_n = 1'b0;
    restart = 1'b0; preset_hi = 1'b0; preset_lo = 1'b0; inc = 1'b0; dec = 1'b0;
    step(3);
    check("rst_target", target_value, 50);
    check("rst_duty", duty_value, 50);
    check("rst_pwm", pwm_out, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;

    // Single inc: target next-next edge, duty 60 after 10 period boundaries.
    step(1);
    inc = 1'b1;
    step(1);
    check("inc_not_yet", target_value, 50);
    step(1);
    inc = 1'b0;
    check("inc_target", target_value, 60);
    check("inc_busy", busy, 1);
    step(996);
    check("inc_duty_k999", duty_value, 59);
    check("inc_busy_k999", busy, 1);
    step(1);
    check("inc_duty_k1000", duty_value, 60);
    check("inc_busy_k1000", busy, 0);

    // Duty 30: exactly 30 high cycles in each of three periods.
    press(4); press(4); press(4);
    check("dec3_target", target_value, 30);
    wait_idle("dec3_idle", 3300);
    check("dec3_duty", duty_value, 30);
    for (int p = 0; p < 3; p++) begin
      count_high(100, hi);
      check("duty30_period", hi, 30);
    end

    // Upper clamp and constant-high output.
    press(1);
    check("phi_target", target_value, 75);
    press(3); press(3);
    check("inc_95", target_value, 95);
    press(3);
    check("inc_clamp_100", target_value, 100);
    press(3);
    check("inc_hold_100", target_value, 100);
    wait_idle("up100_idle", 7500);
    check("duty_100", duty_value, 100);
    count_high(200, hi);
    check("pwm_const_hi", hi, 200);

    // Lower clamp and constant-low output.
    for (int i = 0; i < 10; i++) press(4);
    check("dec_to_0", target_value, 0);
    press(4);
    check("dec_hold_0", target_value, 0);
    wait_idle("down0_idle", 10500);
    check("duty_0", duty_value, 0);
    count_high(200, hi);
    check("pwm_const_lo", hi, 0);

    // Reversal mid-ramp: up toward 75, switch to 25 at duty 60.
    press(0);
    check("restart_duty", duty_value, 50);
    check("restart_busy", busy, 0);
    press(1);
    for (int i = 0; i < 1500 && duty_value != 7'd60; i++) step(1);
    check("hi_reach60", duty_value, 60);
    preset_lo = 1'b1;
    cyc = 0; last = 0; prev = duty_value; max_duty = duty_value;
    for (int i = 1; i <= 4000 && (busy || i <= 2); i++) begin
      step(1);
      cyc++;
      if (i == 2) begin
        preset_lo = 1'b0;
        check("lo_retarget", target_value, 25);
      end
      if (int'(duty_value) > max_duty) max_duty = duty_value;
      if (int'(duty_value) != prev) begin
        check("rev_interval", cyc - last, 100);
        check("rev_step", duty_value, prev - 1);
        last = cyc;
        prev = duty_value;
      end
    end
    check("rev_no_overshoot", max_duty, 60);
    check("rev_final_duty", duty_value, 25);
    check("rev_final_busy", busy, 0);

    // Simultaneous restart + preset_hi + inc during a ramp.
    press(1);
    step(250);
    check("sim_pre_busy", busy, 1);
    restart = 1'b1; preset_hi = 1'b1; inc = 1'b1;
    step(2);
    check("sim_duty", duty_value, 50);
    check("sim_target", target_value, 50);
    check("sim_busy", busy, 0);
    hi = 0;
    for (int i = 0; i < 200 && pwm_out; i++) begin
      hi++;
      step(1);
    end
    check("sim_counter_zero", hi, 50);
    step(300);
    restart = 1'b0; preset_hi = 1'b0; inc = 1'b0;
    step(2);
    check("sim_after_target", target_value, 50);
    check("sim_after_busy", busy, 0);

    // Held inc fires once; async reset mid-ramp with inc still held.
    inc = 1'b1;
    step(500);
    check("held_inc_target", target_value, 60);
    check("held_inc_busy", busy, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_target", target_value, 50);
    check("async_duty", duty_value, 50);
    check("async_pwm", pwm_out, 0);
    check("async_busy", busy, 0);
    step(3);
    rst_n = 1'b1;
    step(300);
    check("post_rst_target", target_value, 50);
    check("post_rst_busy", busy, 0);
    inc = 1'b0;
    step(1);
    press(3);
    check("post_rst_inc", target_value, 60);

    $display("%0d/%0d checks passed", passed_cnt, total_cnt);
    $finish;
  end

endmodule
